// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: baud-count arithmetic and transmitter state encodings.
// Used by the transmitter (pop_to_rs232) and the baud generator; the receiver reuses the same helpers.
package rs232_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic int baud_count_full(input real clk_hz, input real baud_bps);
    return int'(clk_hz / baud_bps);
  endfunction

  function automatic int baud_count_half(input real clk_hz, input real baud_bps);
    return baud_count_full(clk_hz, baud_bps) / 2;
  endfunction

  // One bit above $clog2 so the down-counter can underflow into its MSB.
  function automatic int baud_cnt_width(input int full_count);
    return $clog2(full_count) + 1;
  endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Down-counting baud generator: tick is the counter MSB after underflow, giving one tick
// every BAUD_COUNT_FULL clocks; pre_tick flags the last clock before the tick.
module rs232_baud_gen
  import rs232_pkg::*;
#(
  parameter int BAUD_COUNT_FULL = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = baud_cnt_width(BAUD_COUNT_FULL);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_COUNT_FULL - 2);

  logic [CNT_W-1:0] cnt;

  // Reload to FULL-2: values FULL-2 .. 0 plus the underflowed -1 give FULL clocks per tick.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      cnt <= RELOAD;
    else if (load || tick)
      cnt <= RELOAD;
    else
      cnt <= cnt - CNT_W'(1);
  end

  assign tick     = cnt[CNT_W-1];
  assign pre_tick = (cnt == '0);

endmodule

// File: rtl/pop_to_rs232.sv
// 8N1 serial transmitter that pops bytes from a first-word-fall-through FIFO.
// Optional CTS flow control is enabled by defining RS232TX_CTS_FLOW_EN.
module pop_to_rs232
  import rs232_pkg::*;
#(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0
) (
  input  logic       clock,
  input  logic       resetn,
  output logic       txd_pin,
  input  logic       ctsn_pin,
  input  logic [7:0] idata,
  input  logic       iempty,
  output logic       ienable
);

  localparam int BAUD_COUNT_FULL = baud_count_full(CLOCK_FREQ, BAUD_RATE);

  tx_state_t  state, state_nx;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       arm;
  logic       send_ok;
  logic       tick, pre_tick;

  rs232_baud_gen #(.BAUD_COUNT_FULL(BAUD_COUNT_FULL)) u_baud (
    .clock    (clock),
    .resetn   (resetn),
    .load     (ienable),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

`ifdef RS232TX_CTS_FLOW_EN
  logic [1:0] cts_sync;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      cts_sync <= 2'b11;
    else
      cts_sync <= {cts_sync[0], ctsn_pin};
  end

  assign send_ok = ~cts_sync[1];
`else
  logic ctsn_unused;
  assign ctsn_unused = ctsn_pin;
  assign send_ok     = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      arm <= 1'b0;
    else
      arm <= 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // STOP leaves one clock early; that IDLE clock is the final clock of the stop bit,
  // so a waiting byte is popped exactly when the stop bit ends.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (ienable)                    state_nx = ST_START;
      ST_START: if (tick)                       state_nx = ST_DATA;
      ST_DATA:  if (tick && bit_idx == 3'd7)    state_nx = ST_STOP;
      ST_STOP:  if (pre_tick)                   state_nx = ST_IDLE;
      default:                                  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ienable = (state == ST_IDLE) && arm && !iempty && send_ok;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      txd_pin <= 1'b1;
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else if (ienable) begin
      shreg   <= idata;
      txd_pin <= 1'b0;
      bit_idx <= 3'd0;
    end else if (tick) begin
      unique case (state)
        ST_START: begin
          txd_pin <= shreg[0];
          shreg   <= shreg >> 1;
        end
        ST_DATA: begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            txd_pin <= 1'b1;
          end else begin
            txd_pin <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pop_to_rs232.sv
// Directed bench for pop_to_rs232 at 10 clocks per bit; CTS scenarios run when
// RS232TX_CTS_FLOW_EN is defined, otherwise ctsn_pin is shown to be ignored.
module tb_pop_to_rs232;

  logic       clock;
  logic       resetn;
  logic       txd_pin;
  logic       ctsn_pin;
  logic [7:0] idata;
  logic       iempty;
  logic       ienable;

  logic [7:0] q[$];
  int         pop_cyc[$];
  logic       s_txd, s_ien;
  int         cyc_n;
  int         n_checks;
  int         n_fail;

  pop_to_rs232 #(
    .CLOCK_FREQ (1000000.0),
    .BAUD_RATE  (100000.0)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .txd_pin  (txd_pin),
    .ctsn_pin (ctsn_pin),
    .idata    (idata),
    .iempty   (iempty),
    .ienable  (ienable)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    iempty = (q.size() == 0);
    idata  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: sample outputs on the falling edge, apply the FIFO pop after the rising edge.
  task automatic step();
    @(negedge clock);
    s_txd = txd_pin;
    s_ien = ienable;
    cyc_n++;
    if (s_ien) pop_cyc.push_back(cyc_n);
    @(posedge clock);
    #1;
    if (s_ien && q.size() != 0) void'(q.pop_front());
    drive_fifo();
  endtask

  task automatic wait_pop(input string tag, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step();
      if (s_ien) found = 1'b1;
    end
    chk(tag, found, 1'b1);
  endtask

  // Checks ten 10-clock bit cells; cts_at raises ctsn_pin before that sample index.
  task automatic check_frame(input logic [7:0] b, input string tag, input int cts_at);
    logic [9:0] bits;
    logic [9:0] seen;
    int         early;
    bits  = {1'b1, b, 1'b0};
    early = 0;
    for (int k = 0; k < 10; k++) begin
      seen = '0;
      for (int c = 0; c < 10; c++) begin
        if (k * 10 + c == cts_at) ctsn_pin = 1'b1;
        step();
        seen[c] = s_txd;
        if (s_ien && !(k == 9 && c == 9)) early++;
      end
      chk($sformatf("%s_bit%0d", tag, k), seen, {10{bits[k]}});
    end
    chk({tag, "_midpop"}, early, 0);
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (s_txd !== 1'b1 || s_ien !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int base;
    clock    = 1'b0;
    resetn   = 1'b0;
    ctsn_pin = 1'b0;
    cyc_n    = 0;
    n_checks = 0;
    n_fail   = 0;
    q.push_back(8'hA5);
    drive_fifo();

    repeat (3) @(posedge clock);
    #1;
    chk("rst_txd", txd_pin, 1'b1);
    chk("rst_ienable", ienable, 1'b0);
    resetn = 1'b1;
    step();
    chk("arm_first_cycle", s_ien, 1'b0);

    // Single byte
    wait_pop("pop_a5", 5);
    check_frame(8'hA5, "a5", -1);
    chk("a5_pop_count", pop_cyc.size(), 1);
    idle_check("a5_idle_after", 20);

    // Back-to-back frames
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h55);
    drive_fifo();
    base = pop_cyc.size();
    wait_pop("pop_00", 5);
    check_frame(8'h00, "b2b_00", -1);
    check_frame(8'hFF, "b2b_ff", -1);
    check_frame(8'h55, "b2b_55", -1);
    chk("b2b_pop_count", pop_cyc.size() - base, 3);
    chk("b2b_gap_1", pop_cyc[base + 1] - pop_cyc[base], 100);
    chk("b2b_gap_2", pop_cyc[base + 2] - pop_cyc[base + 1], 100);
    idle_check("b2b_idle_after", 5);

    // Reset in the middle of DATA5
    q.push_back(8'h96);
    q.push_back(8'hC3);
    drive_fifo();
    wait_pop("pop_96", 5);
    repeat (63) step();
    chk("d5_before_reset", txd_pin, 1'b0);
    resetn = 1'b0;
    #1;
    chk("reset_async_txd", txd_pin, 1'b1);
    chk("reset_async_ienable", ienable, 1'b0);
    repeat (2) step();
    resetn = 1'b1;
    base = pop_cyc.size();
    step();
    chk("rearm_first_cycle", s_ien, 1'b0);
    wait_pop("pop_c3", 5);
    check_frame(8'hC3, "after_rst_c3", -1);
    chk("after_rst_pop_count", pop_cyc.size() - base, 1);
    chk("fifo_drained", q.size(), 0);

`ifdef RS232TX_CTS_FLOW_EN
    ctsn_pin = 1'b1;
    q.push_back(8'h3C);
    drive_fifo();
    idle_check("cts_hold_off", 20);
    ctsn_pin = 1'b0;
    wait_pop("cts_release_pop", 3);
    check_frame(8'h3C, "cts_3c", -1);
    q.push_back(8'h5A);
    q.push_back(8'h81);
    drive_fifo();
    wait_pop("pop_5a", 5);
    check_frame(8'h5A, "cts_mid_5a", 42);
    idle_check("cts_no_pop_while_high", 30);
    ctsn_pin = 1'b0;
    wait_pop("cts_resume_pop", 3);
    check_frame(8'h81, "cts_81", -1);
`else
    ctsn_pin = 1'b1;
    q.push_back(8'h3C);
    drive_fifo();
    wait_pop("nocts_pop", 5);
    check_frame(8'h3C, "nocts_3c", -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pop_to_rs232.md
POP_TO_RS232 -- requirements
Module: pop_to_rs232

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQ, real, default 133000000, the clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, real, default 115200, the serial bit rate in bit/s.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port txd_pin, output, 1 bit: serial data, connected to the RXD pin of the receiver.
REQ-006 The module SHALL have port ctsn_pin, input, 1 bit: clear-to-send, active low, connected to the RTSn pin of the receiver.
REQ-007 The module SHALL have port idata, input, 8 bits: head byte of the upstream first-word-fall-through FIFO, valid whenever iempty is 0.
REQ-008 The module SHALL have port iempty, input, 1 bit: upstream FIFO empty flag.
REQ-009 The module SHALL have port ienable, output, 1 bit: one-cycle pop strobe to the upstream FIFO.

Function
REQ-010 The module SHALL send 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1); idle line is 1.
REQ-011 Every bit, including the stop bit, SHALL last exactly BAUD_COUNT_FULL = integer(CLOCK_FREQ/BAUD_RATE) clocks.
REQ-012 The FSM SHALL have states IDLE, START, DATA (bit index 0..7) and STOP.
REQ-013 ienable SHALL be 1 exactly when the state is IDLE, the arm flop (REQ-021) is set, iempty is 0 and the send permission (REQ-024/025) is true.
REQ-014 On a clock edge with ienable=1, idata SHALL be latched into the shift register, txd_pin SHALL become 0, the state SHALL become START and the baud counter SHALL be loaded.
REQ-015 On each baud tick the state SHALL advance START->DATA0->...->DATA7->STOP->IDLE, and txd_pin SHALL take the next bit on that same edge.
REQ-016 txd_pin SHALL be driven directly by a register (glitch-free).
REQ-017 With a non-empty FIFO, the next start bit SHALL begin on the clock after the stop bit ends: zero idle cycles, 10*BAUD_COUNT_FULL clocks per frame.
REQ-018 ienable SHALL never be 1 outside IDLE; exactly one pop SHALL occur per frame.
REQ-019 iempty going to 1 mid-frame SHALL NOT affect the frame in progress.
REQ-020 The baud counter SHALL be at least $clog2(BAUD_COUNT_FULL) bits wide and SHALL use underflow of its MSB as the tick, with no off-by-one across the 10 bits.

Reset
REQ-021 An arm flop SHALL reset to 0 and set to 1 on the first clock after reset release; ienable SHALL be 0 while resetn is 0 and in the first cycle after release.
REQ-022 On reset the outputs SHALL be txd_pin=1 and ienable=0, the state SHALL be IDLE, the shift register 0, the baud counter BAUD_COUNT_FULL-2, and the CTS synchronizer 2'b11.
REQ-023 Reset asserted mid-frame SHALL force txd_pin to 1 immediately (asynchronously); the partial byte SHALL be lost and SHALL NOT be re-popped.

Configuration
REQ-024 With macro RS232TX_CTS_FLOW_EN defined, ctsn_pin SHALL pass through a two-flop synchronizer, and the send permission SHALL be synchronized ctsn == 0; ctsn_pin rising mid-frame SHALL NOT abort the frame, and sampling takes effect only in IDLE.
REQ-025 Without RS232TX_CTS_FLOW_EN, ctsn_pin SHALL be ignored, the synchronizer SHALL be omitted, and the send permission SHALL be constant 1.

Structure
REQ-026 The shared package rs232_pkg SHALL hold the baud-count computation (BAUD_COUNT_FULL, BAUD_COUNT_HALF, width), common to receiver and transmitter.
REQ-027 The package SHALL hold the state encodings.
REQ-028 The baud generator SHALL be a sub-module rs232_baud_gen (load, tick outputs), reusable by the receiver.

Verification (CLOCK_FREQ=1000000, BAUD_RATE=100000: 10 clocks/bit)
REQ-029 Push 0xA5, ctsn_pin=0 -> one ienable pulse; txd_pin = 0,1,0,1,0,0,1,0,1,1 with each level held exactly 10 clocks; then idle at 1.
REQ-030 Queue 0x00, 0xFF, 0x55 back-to-back -> 3 pops spaced exactly 100 clocks apart; no extra idle cycle between stop and start bits.
REQ-031 With the macro defined: ctsn_pin=1, FIFO non-empty -> no ienable and txd_pin stays 1; drop ctsn_pin to 0 -> first ienable within 3 clocks.
REQ-032 With the macro defined: raise ctsn_pin during DATA3 -> current frame completes intact; no new pop until ctsn_pin returns to 0.
REQ-033 Assert resetn during DATA5 -> txd_pin=1 the same cycle; after release, the next frame starts with a fresh pop and correct timing.
REQ-034 Without the macro: hold ctsn_pin=1, push 0x3C -> frame 0,0,0,1,1,1,1,0,0,1 transmitted normally.
